// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel RGB LED PWM/breathe controller driving open-drain sink enables
// and per-channel current bits, with glitch-free updates at period boundaries.
module rgb_pwm_ctrl #(
    parameter  int NCH     = 3,
    parameter  int PWM_W   = 8,
    parameter  int CUR_W   = 6,
    parameter  int PRESC_W = 8,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   poc,
    input  logic [PRESC_W-1:0]     presc,
    input  logic                   wr_en,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [PWM_W-1:0]       wr_duty,
    input  logic [CUR_W-1:0]       wr_cur,
    input  logic                   wr_mode,
    output logic [NCH-1:0]         sink_en,
    output logic [NCH*CUR_W-1:0]   cbit_out,
    output logic                   period_tick
);
    localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic rst_s1_q, rst_s2_q;
    logic rst_int_n;

    // Reset asserts immediately, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_s1_q <= 1'b0;
            rst_s2_q <= 1'b0;
        end else begin
            rst_s1_q <= 1'b1;
            rst_s2_q <= rst_s1_q;
        end
    end
    assign rst_int_n = rst_s2_q;

    logic                 run, tick, boundary;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PWM_W-1:0]     cnt_q, cnt_d;
    logic [NCH-1:0]       hit_vec;
    logic [NCH-1:0]       sink_en_q, sink_en_d;
    logic [NCH*CUR_W-1:0] cbit_q, cbit_d;
    logic                 period_tick_q;

    assign run      = en & ~poc;
    assign tick     = run & (presc_q == presc);
    assign boundary = tick & (cnt_q == CNT_LAST);

    // >= also catches a live presc drop below the running count.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (!run) begin
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            presc_d = (presc_q >= presc) ? '0 : presc_q + PRESC_W'(1);
            if (tick) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + PWM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [PWM_W-1:0] pduty_q, aduty_q, level_q, level_d, src_duty, d_eff;
        logic [CUR_W-1:0] pcur_q, acur_q, src_cur;
        logic             pmode_q, amode_q, dir_q, dir_d, src_mode, wr_hit;

        assign wr_hit   = wr_en & (wr_ch == CH_W'(k));
        assign src_duty = wr_hit ? wr_duty : pduty_q;
        assign src_cur  = wr_hit ? wr_cur  : pcur_q;
        assign src_mode = wr_hit ? wr_mode : pmode_q;

        // dir 0 = counting up toward duty, 1 = counting down toward 0.
        always_comb begin
            level_d = level_q;
            dir_d   = dir_q;
            if (src_mode && !amode_q) begin
                level_d = '0;
                dir_d   = 1'b0;
            end else if (src_mode) begin
                if (!dir_q) begin
                    if (level_q < src_duty) begin
                        level_d = level_q + PWM_W'(1);
                    end else if (level_q > src_duty) begin
                        level_d = level_q - PWM_W'(1);
                    end
                    dir_d = (level_d == src_duty);
                end else begin
                    if (level_q != '0) begin
                        level_d = level_q - PWM_W'(1);
                    end
                    dir_d = (level_d != '0);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                pduty_q <= '0;
                pcur_q  <= '0;
                pmode_q <= 1'b0;
                aduty_q <= '0;
                acur_q  <= '0;
                amode_q <= 1'b0;
                level_q <= '0;
                dir_q   <= 1'b0;
            end else begin
                if (wr_hit) begin
                    pduty_q <= wr_duty;
                    pcur_q  <= wr_cur;
                    pmode_q <= wr_mode;
                end
                if (boundary) begin
                    aduty_q <= src_duty;
                    acur_q  <= src_cur;
                    amode_q <= src_mode;
                    level_q <= level_d;
                    dir_q   <= dir_d;
                end
            end
        end

        assign d_eff      = amode_q ? level_q : aduty_q;
        assign hit_vec[k] = (cnt_q < d_eff) && (acur_q != '0);
        assign cbit_d[k*CUR_W +: CUR_W] = (run && hit_vec[k]) ? acur_q : '0;
    end

    assign sink_en_d = run ? hit_vec : '0;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sink_en_q     <= '0;
            cbit_q        <= '0;
            period_tick_q <= 1'b0;
        end else begin
            sink_en_q     <= sink_en_d;
            cbit_q        <= cbit_d;
            period_tick_q <= boundary;
        end
    end

    assign sink_en     = sink_en_q;
    assign cbit_out    = cbit_q;
    assign period_tick = period_tick_q;
endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed bench for rgb_pwm_ctrl: per-period on-time measurement against a
// queue of expected on-times, plus reset, poc, prescaler and extreme cases.
module tb_rgb_pwm_ctrl;
    localparam int NCH   = 3;
    localparam int CUR_W = 6;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic                 poc;
    logic [7:0]           presc;
    logic                 wr_en;
    logic [1:0]           wr_ch;
    logic [7:0]           wr_duty;
    logic [CUR_W-1:0]     wr_cur;
    logic                 wr_mode;
    logic [NCH-1:0]       sink_en;
    logic [NCH*CUR_W-1:0] cbit_out;
    logic                 period_tick;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    rgb_pwm_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .poc(poc), .presc(presc),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .wr_cur(wr_cur),
        .wr_mode(wr_mode), .sink_en(sink_en), .cbit_out(cbit_out),
        .period_tick(period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s: observed %0d expected <empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] duty,
                      input logic [CUR_W-1:0] cur, input logic mode);
        wr_en = 1'b1; wr_ch = ch; wr_duty = duty; wr_cur = cur; wr_mode = mode;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sync_tick(input int budget);
        int n = 0;
        while (period_tick !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sync_tick", 32'(period_tick), 32'd1);
    endtask

    task automatic measure(input int ch, input int len, input logic [CUR_W-1:0] cur,
                           output int on_cnt, output int cbad, output int tbad);
        on_cnt = 0; cbad = 0; tbad = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (sink_en[ch]) on_cnt++;
            if (cbit_out[ch*CUR_W +: CUR_W] !== (sink_en[ch] ? cur : '0)) cbad++;
            if (period_tick !== (i == len - 1)) tbad++;
        end
    endtask

    // One period starting at a period_tick sample; on-time popped from the queue.
    task automatic period(input string tag, input int ch, input int len, input logic [CUR_W-1:0] cur);
        int on_cnt, cbad, tbad;
        measure(ch, len, cur, on_cnt, cbad, tbad);
        check_sb({tag, "_on"}, 32'(on_cnt));
        check({tag, "_cbit"}, 32'(cbad), 32'd0);
        check({tag, "_tick"}, 32'(tbad), 32'd0);
    endtask

    initial begin
        int on_cnt, ticks, cbad;
        rst_n = 1'b0; en = 1'b1; poc = 1'b0; presc = 8'd0;
        wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_cur = '0; wr_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sink", 32'(sink_en), 32'd0);
        check("rst_cbit", 32'(cbit_out), 32'd0);
        check("rst_tick", 32'(period_tick), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_sink", 32'(sink_en), 32'd0);

        // Static duty 64
        wr(2'd0, 8'd64, 6'h3F, 1'b0);
        exp_q.push_back(32'd64); exp_q.push_back(32'd64);
        sync_tick(600);
        period("static64_a", 0, 255, 6'h3F);
        period("static64_b", 0, 255, 6'h3F);

        // Extremes
        wr(2'd0, 8'd0, 6'h3F, 1'b0);
        exp_q.push_back(32'd0);
        sync_tick(600);
        period("duty0", 0, 255, 6'h3F);
        wr(2'd0, 8'd255, 6'h3F, 1'b0);
        repeat (3) exp_q.push_back(32'd255);
        sync_tick(600);
        repeat (3) period("duty255", 0, 255, 6'h3F);
        wr(2'd0, 8'd128, 6'h00, 1'b0);
        exp_q.push_back(32'd0);
        sync_tick(600);
        period("cur0", 0, 255, 6'h00);

        // Glitch-free update: duty 200 written at cnt=100 while 50 is active
        wr(2'd0, 8'd50, 6'h3F, 1'b0);
        sync_tick(600);
        on_cnt = 0;
        exp_q.push_back(32'd50);
        for (int i = 0; i < 255; i++) begin
            if (i == 100) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 8'd200; wr_cur = 6'h3F; wr_mode = 1'b0;
            end
            if (i == 101) wr_en = 1'b0;
            @(negedge clk);
            if (sink_en[0]) on_cnt++;
        end
        check_sb("glitch_cur_on", 32'(on_cnt));
        check("glitch_tick", 32'(period_tick), 32'd1);
        exp_q.push_back(32'd200);
        period("glitch_next", 0, 255, 6'h3F);

        // Breathe with duty 3: level restarts at 0 on the static-to-breathe switch
        wr(2'd0, 8'd3, 6'h3F, 1'b1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
        exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        sync_tick(600);
        repeat (8) period("breathe", 0, 255, 6'h3F);

        // Multi-channel, out-of-range write ignored
        wr(2'd0, 8'd128, 6'h3F, 1'b0);
        wr(2'd2, 8'd10, 6'h05, 1'b0);
        wr(2'd3, 8'd255, 6'h3F, 1'b0);
        exp_q.push_back(32'd10); exp_q.push_back(32'd0);
        sync_tick(600);
        period("ch2", 2, 255, 6'h05);
        period("ch1_off", 1, 255, 6'h00);

        // poc mid-period at cnt=30, write while run is low
        repeat (30) @(negedge clk);
        check("pre_poc_sink", 32'(sink_en[0]), 32'd1);
        poc = 1'b1;
        @(negedge clk);
        check("poc_sink", 32'(sink_en), 32'd0);
        check("poc_cbit", 32'(cbit_out), 32'd0);
        wr(2'd0, 8'd100, 6'h3F, 1'b0);
        ticks = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (period_tick || sink_en != '0) ticks++;
        end
        check("poc_quiet", 32'(ticks), 32'd0);
        poc = 1'b0;
        exp_q.push_back(32'd128); exp_q.push_back(32'd100);
        period("poc_restart", 0, 255, 6'h3F);
        period("poc_applied", 0, 255, 6'h3F);

        // Prescaler: presc=1 doubles the period
        presc = 8'd1;
        exp_q.push_back(32'd200);
        sync_tick(1200);
        period("presc1", 0, 510, 6'h3F);
        presc = 8'd0;
        sync_tick(1200);

        // Async reset with no clock edge in between
        repeat (20) @(negedge clk);
        check("pre_rst_sink", 32'(sink_en[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sink", 32'(sink_en), 32'd0);
        check("arst_cbit", 32'(cbit_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks = 0; on_cnt = 0; cbad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (period_tick) ticks++;
            if (sink_en != '0) on_cnt++;
            if (cbit_out != '0) cbad++;
        end
        check("post_rst_on", 32'(on_cnt), 32'd0);
        check("post_rst_cbit", 32'(cbad), 32'd0);
        check("post_rst_ticks", 32'(ticks), 32'd2);
        wr(2'd0, 8'd64, 6'h3F, 1'b0);
        exp_q.push_back(32'd64);
        sync_tick(600);
        period("post_rst_wr", 0, 255, 6'h3F);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
